neuron_mac_pipe: RTL and testbench
==================================

# neuron_mac_pipe

Clocked, pipelined fixed-point neuron: streams weight/input pairs of configurable length through a registered multiplier and accumulator, then applies a selectable activation (identity, ReLU, leaky ReLU), saturates, and presents one result per vector on a valid/ready output. It is the synchronous, back-pressure-aware successor to the team's event-driven MAC-plus-ReLU neuron. It sits between the weight/activation streamers and the layer output buffer.

## Interface
- N, 32, data width of W, X and result (signed two's complement)
- FRAC, 20, fractional bits (format Q(N-FRAC).FRAC; default Q12.20)
- G, 8, accumulator guard bits; accumulator width ACC_W = N+G
- LEAK_SH, 3, leaky-ReLU negative slope = 2^-LEAK_SH

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  term pair valid
- in_ready  out  1  block accepts a term this cycle
- w  in  N  weight, signed
- x  in  N  input, signed
- in_last  in  1  marks final term of the vector
- act_mode  in  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 reserved (behaves as identity)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N  activated, saturated result
- out_ovf  out  1  saturation occurred anywhere in this vector

## Operation
- Term accepted when in_valid && in_ready.
- Stage 1 (MUL): p = signed w*x (2N bits), then p >>> FRAC (arithmetic, truncation toward -inf), sign-extended/saturated to ACC_W; registered with last flag and act_mode.
- Stage 2 (ACC): acc <= sat_ACC_W(acc + p); saturating add, sticky ovf set on saturation.
- Stage 3 (ACT): on last term, apply activation to acc: identity; ReLU (acc<0 -> 0); leaky (acc<0 -> acc >>> LEAK_SH). Then saturate to N bits (max 2^(N-1)-1, min -2^(N-1)); ovf |= clamp. Register into out_data/out_ovf.
- act_mode is sampled only with the in_last term; other beats ignore it.
- FSM:
  - ACC: in_ready=1. Accepting in_last -> FLUSH.
  - FLUSH: in_ready=0; waits for last term to traverse MUL and ACC (2 cycles), then -> OUT.
  - OUT: out_valid=1, in_ready=0, out_data/out_ovf stable. On out_valid && out_ready: acc and sticky ovf cleared, -> ACC.
- Single-term vector (first beat has in_last) is legal.
- in_valid low mid-vector inserts bubbles; accumulator holds.
- Reserved act_mode=3 treated as identity, no error.

## Timing
- Reset (async assert, sync release): state ACC, acc=0, pipeline valids=0, out_valid=0, out_data=0, out_ovf=0; in_ready=1 from the first clock edge after release.
- Throughput: one term per cycle within a vector.
- Latency: in_last accepted at edge t -> out_valid=1 after edge t+3.
- Earliest next vector term: cycle following output handshake (in_ready rises the edge after out_valid&&out_ready).
- out_ready held high with no back-pressure: per-vector overhead 4 cycles beyond L terms.
- Reset mid-vector or while out_valid held: partial sum and pending result discarded, no output emitted.
- out_ready asserted while out_valid=0: ignored.

## Test plan
- 4-term vector, w=0x00200000 (2.0), x=0x00180000 (1.5), mode 0 -> out_data=0x00C00000 (12.0), out_ovf=0, out_valid 3 cycles after last beat.
- 2-term vector w=0x00100000, x=0xFF800000 (-8.0) twice, mode 1 -> 0x00000000; same with mode 2 -> 0xFFE00000 (-2.0 = -16/8).
- Saturation: w=x=0x7FFFFFFF, 1 term, mode 0 -> out_data=0x7FFFFFFF, out_ovf=1; next vector 1.0*1.0 -> 0x00100000, out_ovf=0 (sticky cleared).
- Back-pressure: out_ready low 5 cycles after out_valid -> out_valid, out_data stable, in_ready=0; handshake -> in_ready=1 next cycle.
- Bubbles: 3-term vector with in_valid gaps of 2 cycles, 1.0*1.0 each -> 0x00300000.
- Reset asserted mid-vector after 2 terms, then fresh 1-term vector 1.0*1.0 -> 0x00100000; no spurious out_valid.

Source files
------------

// File: rtl/neuron_mac_pipe.sv
// Pipelined fixed-point neuron: MUL -> saturating ACC -> activation/clamp,
// one result per vector on a valid/ready output with back-pressure.
module neuron_mac_pipe #(
    parameter int N       = 32,
    parameter int FRAC    = 20,
    parameter int G       = 8,
    parameter int LEAK_SH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] w,
    input  logic [N-1:0] x,
    input  logic         in_last,
    input  logic [1:0]   act_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);
    localparam int ACC_W = N + G;
    localparam int P_W   = 2 * N;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [1:0] MODE_RELU  = 2'd1;
    localparam logic [1:0] MODE_LEAKY = 2'd2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [N-1:0]            OUT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]            OUT_MIN = {1'b1, {(N-1){1'b0}}};

    logic [1:0] state_q, state_d;
    logic       run_q;
    logic       accept;
    logic       out_hs;

    assign in_ready  = run_q && (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign accept    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // ---------------- Stage 1: multiply, rescale, saturate to ACC_W
    logic signed [P_W-1:0]   w_ext, x_ext, prod, prod_sh;
    logic [P_W-ACC_W:0]      prod_hi;
    logic                    mul_sat_d;
    logic signed [ACC_W-1:0] mul_d;

    logic signed [ACC_W-1:0] mul_q;
    logic                    mul_valid_q, mul_last_q, mul_sat_q;
    logic [1:0]              mul_mode_q;

    assign w_ext   = {{N{w[N-1]}}, w};
    assign x_ext   = {{N{x[N-1]}}, x};
    assign prod    = w_ext * x_ext;
    assign prod_sh = prod >>> FRAC;
    // Bits above the accumulator sign bit must all match it, else the term saturates.
    assign prod_hi = prod_sh[P_W-1:ACC_W-1];

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        mul_sat_d = !((&prod_hi) || !(|prod_hi));
        mul_d     = prod_sh[ACC_W-1:0];
        if (mul_sat_d) begin
            mul_d = prod_sh[P_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_valid_q <= 1'b0;
            mul_last_q  <= 1'b0;
            mul_sat_q   <= 1'b0;
            mul_mode_q  <= 2'd0;
            mul_q       <= '0;
        end else begin
            mul_valid_q <= accept;
            mul_last_q  <= accept && in_last;
            if (accept) begin
                mul_q     <= mul_d;
                mul_sat_q <= mul_sat_d;
                if (in_last) begin
                    mul_mode_q <= act_mode;
                end
            end
        end
    end

    // ---------------- Stage 2: saturating accumulate with sticky overflow
    logic signed [ACC_W:0]   sum;
    logic                    add_sat;
    logic signed [ACC_W-1:0] acc_d;

    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q, acc_last_q;
    logic [1:0]              acc_mode_q;

    assign sum = {acc_q[ACC_W-1], acc_q} + {mul_q[ACC_W-1], mul_q};

    always_comb begin
        add_sat = (sum[ACC_W] != sum[ACC_W-1]);
        acc_d   = sum[ACC_W-1:0];
        if (add_sat) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            acc_last_q <= 1'b0;
            acc_mode_q <= 2'd0;
        end else begin
            acc_last_q <= mul_valid_q && mul_last_q;
            if (out_hs) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (mul_valid_q) begin
                acc_q <= acc_d;
                ovf_q <= ovf_q || mul_sat_q || add_sat;
                if (mul_last_q) begin
                    acc_mode_q <= mul_mode_q;
                end
            end
        end
    end

    // ---------------- Stage 3: activation and clamp to N bits
    logic signed [ACC_W-1:0] act_val;
    logic [ACC_W-N:0]        act_hi;
    logic                    clamp;
    logic [N-1:0]            res_d;

    logic [N-1:0] out_data_q;
    logic         out_ovf_q, res_done_q;

    assign act_hi = act_val[ACC_W-1:N-1];

    always_comb begin
        act_val = acc_q;
        if (acc_q[ACC_W-1]) begin
            if (acc_mode_q == MODE_RELU) begin
                act_val = '0;
            end else if (acc_mode_q == MODE_LEAKY) begin
                act_val = acc_q >>> LEAK_SH;
            end
        end
        clamp = !((&act_hi) || !(|act_hi));
        res_d = act_val[N-1:0];
        if (clamp) begin
            res_d = act_val[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            res_done_q <= 1'b0;
        end else begin
            res_done_q <= acc_last_q;
            if (acc_last_q) begin
                out_data_q <= res_d;
                out_ovf_q  <= ovf_q || clamp;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;

    // ---------------- Control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:   if (accept && in_last) state_d = ST_FLUSH;
            ST_FLUSH: if (res_done_q)        state_d = ST_OUT;
            ST_OUT:   if (out_ready)         state_d = ST_ACC;
            default:                         state_d = ST_ACC;
        endcase
    end

    // run_q holds off in_ready until the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACC;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_neuron_mac_pipe.sv
// Scoreboard bench for neuron_mac_pipe: directed vectors from known values
// plus random vectors scored by a wide-integer reference model.
module tb_neuron_mac_pipe;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [N-1:0] w, x;
    logic [1:0]   act_mode;
    logic         out_valid, out_ready, out_ovf;
    logic [N-1:0] out_data;

    neuron_mac_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .w(w), .x(x), .in_last(in_last), .act_mode(act_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [N-1:0] vw[$];
    logic [N-1:0] vx[$];
    int           n_vec = 0;
    int           n_err = 0;

    localparam logic [N-1:0] ONE = 32'h0010_0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Results are compared on the negedge preceding the handshake edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("out_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    function automatic longint clamp(input longint v, input longint lo, input longint hi,
                                     inout logic f);
        if (v > hi) begin f = 1'b1; return hi; end
        if (v < lo) begin f = 1'b1; return lo; end
        return v;
    endfunction

    function automatic exp_t model(input logic [1:0] mode);
        longint acc, p;
        logic   ovf;
        exp_t   r;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < vw.size(); i++) begin
            p   = longint'($signed(vw[i])) * longint'($signed(vx[i]));
            p   = p >>> 20;
            p   = clamp(p, -(64'sd1 <<< 39), (64'sd1 <<< 39) - 1, ovf);
            acc = clamp(acc + p, -(64'sd1 <<< 39), (64'sd1 <<< 39) - 1, ovf);
        end
        if (acc < 0 && mode == 2'd1) acc = 0;
        if (acc < 0 && mode == 2'd2) acc = acc >>> 3;
        acc    = clamp(acc, -(64'sd1 <<< 31), (64'sd1 <<< 31) - 1, ovf);
        r.data = acc[N-1:0];
        r.ovf  = ovf;
        return r;
    endfunction

    task automatic send_term(input logic [N-1:0] tw, input logic [N-1:0] tx,
                             input logic last, input logic [1:0] mode);
        int cnt = 0;
        in_valid = 1'b1; w = tw; x = tx; in_last = last; act_mode = mode;
        @(negedge clk);
        while (!in_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0; w = '0; x = '0;
    endtask

    // Non-last beats carry a different act_mode, which must be ignored.
    task automatic run_vector(input logic [1:0] mode, input int gap, input exp_t e);
        sb.push_back(e);
        for (int i = 0; i < vw.size(); i++) begin
            send_term(vw[i], vx[i], i == vw.size() - 1,
                      (i == vw.size() - 1) ? mode : ~mode);
            if (i != vw.size() - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Called 1ns after the last-term edge; out_valid is due on the 4th negedge.
    task automatic wait_out(input string tag);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            check("in_ready_busy", 64'(in_ready), 64'd0);
        end while (!out_valid && cnt < 50);
        check(tag, 64'(cnt), 64'd4);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [N-1:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        return e;
    endfunction

    task automatic fill(input logic [N-1:0] tw, input logic [N-1:0] tx, input int len);
        vw.delete();
        vx.delete();
        for (int i = 0; i < len; i++) begin
            vw.push_back(tw);
            vx.push_back(tx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; w = '0; x = '0;
        act_mode = 2'd0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rdy_after_reset", 64'(in_ready), 64'd1);

        // 4 x (2.0 * 1.5), identity
        fill(32'h0020_0000, 32'h0018_0000, 4);
        run_vector(2'd0, 0, mk(32'h00C0_0000, 1'b0));
        wait_out("lat_identity");

        // 2 x (1.0 * -8.0): ReLU then leaky
        fill(ONE, 32'hFF80_0000, 2);
        run_vector(2'd1, 0, mk(32'h0000_0000, 1'b0));
        wait_out("lat_relu");
        run_vector(2'd2, 0, mk(32'hFFE0_0000, 1'b0));
        wait_out("lat_leaky");

        // Saturation, then sticky overflow must be cleared
        fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1);
        run_vector(2'd0, 0, mk(32'h7FFF_FFFF, 1'b1));
        wait_out("lat_sat");
        fill(ONE, ONE, 1);
        run_vector(2'd0, 0, mk(ONE, 1'b0));
        wait_out("lat_after_sat");

        // Back-pressure: (1.0 * -0.5) + (3.0 * 0.25) = 0.25
        out_ready = 1'b0;
        vw.delete(); vx.delete();
        vw.push_back(ONE);          vx.push_back(32'hFFF8_0000);
        vw.push_back(32'h0030_0000); vx.push_back(32'h0004_0000);
        run_vector(2'd0, 0, mk(32'h0004_0000, 1'b0));
        begin
            int cnt = 0;
            while (!out_valid && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            check("bp_out_valid_seen", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, 64'h0004_0000);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_rdy_after_hs", 64'(in_ready), 64'd1);
        check("bp_valid_after_hs", 64'(out_valid), 64'd0);

        // Bubbles: 3 x (1.0 * 1.0) with 2-cycle gaps
        fill(ONE, ONE, 3);
        run_vector(2'd0, 2, mk(32'h0030_0000, 1'b0));
        wait_out("lat_bubbles");

        // Reset mid-vector discards the partial sum
        send_term(ONE, ONE, 1'b0, 2'd0);
        send_term(ONE, ONE, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rdy", 64'(in_ready), 64'd1);
        fill(ONE, ONE, 1);
        run_vector(2'd0, 0, mk(ONE, 1'b0));
        wait_out("lat_after_rst");

        // Random vectors scored by the reference model
        for (int v = 0; v < 8; v++) begin
            logic [1:0] mode;
            int         len;
            len  = $urandom_range(1, 5);
            mode = 2'($urandom_range(0, 3));
            vw.delete(); vx.delete();
            for (int i = 0; i < len; i++) begin
                if (v < 6) begin
                    vw.push_back(N'($signed(24'($urandom))));
                    vx.push_back(N'($signed(24'($urandom))));
                end else begin
                    vw.push_back($urandom);
                    vx.push_back($urandom);
                end
            end
            e = model(mode);
            run_vector(mode, int'($urandom_range(0, 1)), e);
            wait_out("lat_random");
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
